// File: rtl/cordic_req_arbiter.sv
// rtl/cordic_req_arbiter.sv - round-robin arbiter sharing one CORDIC engine; optional macro CORDIC_ARB_SYNC_CHECK_EN
module cordic_req_arbiter #(
  parameter int                    DATA_WIDTH = 18,
  parameter int                    N_REQ      = 4,
  parameter int                    LATENCY    = 18,
  parameter logic [DATA_WIDTH-1:0] K_INIT     = 18'h026DE,
  parameter logic [DATA_WIDTH-1:0] TWO_PI     = 18'h19220
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_enable,
  input  logic [N_REQ-1:0]            i_req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] i_req_alpha,
  output logic [N_REQ-1:0]            o_req_ready,
  output logic [N_REQ-1:0]            o_req_err,
  output logic [DATA_WIDTH-1:0]       o_eng_x,
  output logic [DATA_WIDTH-1:0]       o_eng_y,
  output logic [DATA_WIDTH-1:0]       o_eng_alpha,
  output logic                        o_eng_valid,
  input  logic [DATA_WIDTH-1:0]       i_eng_cos,
  input  logic [DATA_WIDTH-1:0]       i_eng_sin,
  input  logic                        i_eng_valid,
  output logic [N_REQ-1:0]            o_res_valid,
  output logic [DATA_WIDTH-1:0]       o_res_cos,
  output logic [DATA_WIDTH-1:0]       o_res_sin,
  output logic                        o_busy,
  output logic                        o_sync_err
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [ID_W-1:0]       last;
  logic [ID_W-1:0]       issue_id;
  logic [N_REQ-1:0]      grant;
  logic [ID_W-1:0]       grant_id;
  logic [DATA_WIDTH-1:0] grant_alpha;
  logic                  found;
  logic                  hs;
  logic                  legal;

  logic [LATENCY-1:0]    tag_v;
  logic [ID_W-1:0]       tag_id [LATENCY];
  logic                  tail_v;
  logic [ID_W-1:0]       tail_id;

  // Round-robin search starting one past the last granted requester
  always_comb begin
    int idx;
    idx         = 0;
    grant       = '0;
    grant_id    = '0;
    grant_alpha = '0;
    found       = 1'b0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx = (int'(last) + off) % N_REQ;
      if (i_enable && !found && i_req_valid[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = ID_W'(idx);
        grant_alpha = i_req_alpha[idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign o_req_ready = grant;
  assign hs          = found;
  assign legal       = !grant_alpha[DATA_WIDTH-1] && (grant_alpha < TWO_PI);

  // Issue stage: range check, seed the engine, or flag a rejected angle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last        <= ID_W'(N_REQ - 1);
      issue_id    <= '0;
      o_eng_valid <= 1'b0;
      o_eng_alpha <= '0;
      o_eng_x     <= '0;
      o_eng_y     <= '0;
      o_req_err   <= '0;
    end else begin
      o_eng_valid <= hs && legal;
      o_req_err   <= (hs && !legal) ? grant : '0;
      if (hs) begin
        last <= grant_id;
      end
      if (hs && legal) begin
        issue_id    <= grant_id;
        o_eng_alpha <= grant_alpha;
        o_eng_x     <= K_INIT;
        o_eng_y     <= '0;
      end
    end
  end

  // Tag pipeline fed from the issue register so its tail lines up with the engine output
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tag_v <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        tag_id[i] <= '0;
      end
    end else begin
      tag_v[0]  <= o_eng_valid;
      tag_id[0] <= issue_id;
      for (int i = 1; i < LATENCY; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  assign tail_v  = tag_v[LATENCY-1];
  assign tail_id = tag_id[LATENCY-1];

  // Route the engine result to the requester named by the tail tag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_res_valid <= '0;
      o_res_cos   <= '0;
      o_res_sin   <= '0;
    end else begin
      o_res_valid <= '0;
      if (tail_v) begin
        o_res_valid[tail_id] <= 1'b1;
        o_res_cos            <= i_eng_cos;
        o_res_sin            <= i_eng_sin;
      end
    end
  end

  assign o_busy = o_eng_valid || (|tag_v);

`ifdef CORDIC_ARB_SYNC_CHECK_EN
  localparam int                MW       = $clog2(LATENCY + 2);
  localparam logic [MW-1:0]     MASK_END = MW'(LATENCY + 1);
  logic [MW-1:0]                mask_cnt;

  // Sticky tag/engine disagreement, ignored while stale engine valids drain after reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mask_cnt   <= '0;
      o_sync_err <= 1'b0;
    end else if (mask_cnt != MASK_END) begin
      mask_cnt <= mask_cnt + 1'b1;
    end else if (tail_v != i_eng_valid) begin
      o_sync_err <= 1'b1;
    end
  end
`else
  logic unused_eng_valid;
  assign unused_eng_valid = i_eng_valid;
  assign o_sync_err       = 1'b0;
`endif

endmodule

// File: tb/tb_cordic_req_arbiter.sv
// tb/tb_cordic_req_arbiter.sv - directed self-checking bench for cordic_req_arbiter
module tb_cordic_req_arbiter;

  localparam int DW = 18;
  localparam int N  = 4;
  localparam int L  = 18;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [N-1:0]  req_valid;
  logic [N*DW-1:0] req_alpha;
  logic [N-1:0]  req_ready, req_err, res_valid;
  logic [DW-1:0] eng_x, eng_y, eng_alpha, res_cos, res_sin;
  logic [DW-1:0] eng_cos, eng_sin;
  logic          eng_valid_o, eng_valid_i, busy, sync_err;
  logic          drop;

  int cyc = 0;
  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    int            c;
    logic [N-1:0]  v;
    logic [DW-1:0] cos;
    logic [DW-1:0] sin;
  } res_t;
  res_t res_q[$];

  cordic_req_arbiter dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_enable    (enable),
    .i_req_valid (req_valid),
    .i_req_alpha (req_alpha),
    .o_req_ready (req_ready),
    .o_req_err   (req_err),
    .o_eng_x     (eng_x),
    .o_eng_y     (eng_y),
    .o_eng_alpha (eng_alpha),
    .o_eng_valid (eng_valid_o),
    .i_eng_cos   (eng_cos),
    .i_eng_sin   (eng_sin),
    .i_eng_valid (eng_valid_i),
    .o_res_valid (res_valid),
    .o_res_cos   (res_cos),
    .o_res_sin   (res_sin),
    .o_busy      (busy),
    .o_sync_err  (sync_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in engine: fixed LATENCY delay, known answers for 0 and pi, tagged data otherwise
  logic          pipe_v [L];
  logic [DW-1:0] pipe_a [L];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < L; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_a[i] <= '0;
      end
    end else begin
      pipe_v[0] <= eng_valid_o;
      pipe_a[0] <= eng_alpha;
      for (int i = 1; i < L; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_a[i] <= pipe_a[i-1];
      end
    end
  end

  function automatic logic [DW-1:0] f_cos(input logic [DW-1:0] a);
    if (a == 18'h00000) return 18'h04000;
    if (a == 18'h0C910) return 18'h3C000;
    return a;
  endfunction

  function automatic logic [DW-1:0] f_sin(input logic [DW-1:0] a);
    if (a == 18'h00000 || a == 18'h0C910) return 18'h00000;
    return ~a;
  endfunction

  assign eng_valid_i = pipe_v[L-1] && !drop;
  assign eng_cos     = f_cos(pipe_a[L-1]);
  assign eng_sin     = f_sin(pipe_a[L-1]);

  always @(negedge clk) begin
    if (rst_n && |res_valid) res_q.push_back('{cyc, res_valid, res_cos, res_sin});
  end

  task automatic set_alpha(input int k, input logic [DW-1:0] a);
    req_alpha[k*DW +: DW] = a;
  endtask

  task automatic wait_results(input int n, input int budget);
    for (int i = 0; i < budget && res_q.size() < n; i++) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; req_valid = '0; req_alpha = '0; drop = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total_cnt++; if (eng_valid_o !== 1'b0) $display("FAIL reset_eng_valid got %b want 0", eng_valid_o); else pass_cnt++;
    total_cnt++; if (res_valid !== 4'b0000) $display("FAIL reset_res_valid got %b want 0000", res_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (eng_x !== 18'h0) $display("FAIL reset_eng_x got %h want 00000", eng_x); else pass_cnt++;
    total_cnt++; if (req_err !== 4'b0000) $display("FAIL reset_req_err got %b want 0000", req_err); else pass_cnt++;
    total_cnt++; if (sync_err !== 1'b0) $display("FAIL reset_sync_err got %b want 0", sync_err); else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int c0;
    res_q.delete();
    @(negedge clk);
    req_valid = 4'b0001; set_alpha(0, 18'h00000);
    #1;
    c0 = cyc;
    total_cnt++; if (req_ready !== 4'b0001) $display("FAIL single_ready got %b want 0001", req_ready); else pass_cnt++;
    @(negedge clk);
    req_valid = '0;
    #1;
    total_cnt++; if (eng_valid_o !== 1'b1) $display("FAIL single_eng_valid got %b want 1", eng_valid_o); else pass_cnt++;
    total_cnt++; if (eng_x !== 18'h026DE) $display("FAIL single_eng_x got %h want 026de", eng_x); else pass_cnt++;
    total_cnt++; if (eng_y !== 18'h00000) $display("FAIL single_eng_y got %h want 00000", eng_y); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL single_busy got %b want 1", busy); else pass_cnt++;
    wait_results(1, 40);
    total_cnt++;
    if (res_q.size() != 1) $display("FAIL single_result_count got %0d want 1", res_q.size());
    else begin
      pass_cnt++;
      total_cnt++; if (res_q[0].c !== c0 + 20) $display("FAIL single_latency got %0d want %0d", res_q[0].c - c0, 20); else pass_cnt++;
      total_cnt++; if (res_q[0].v !== 4'b0001) $display("FAIL single_res_valid got %b want 0001", res_q[0].v); else pass_cnt++;
      total_cnt++; if (res_q[0].cos !== 18'h04000) $display("FAIL single_cos got %h want 04000", res_q[0].cos); else pass_cnt++;
      total_cnt++; if (res_q[0].sin !== 18'h00000) $display("FAIL single_sin got %h want 00000", res_q[0].sin); else pass_cnt++;
    end
  endtask

  task automatic test_quadrant();
    int c0;
    res_q.delete();
    @(negedge clk);
    req_valid = 4'b0100; set_alpha(2, 18'h0C910);
    #1;
    c0 = cyc;
    total_cnt++; if (req_ready !== 4'b0100) $display("FAIL quad_ready got %b want 0100", req_ready); else pass_cnt++;
    @(negedge clk);
    req_valid = '0;
    #1;
    total_cnt++; if (eng_alpha !== 18'h0C910) $display("FAIL quad_eng_alpha got %h want 0c910", eng_alpha); else pass_cnt++;
    wait_results(1, 40);
    total_cnt++;
    if (res_q.size() != 1) $display("FAIL quad_result_count got %0d want 1", res_q.size());
    else begin
      pass_cnt++;
      total_cnt++; if (res_q[0].c !== c0 + 20) $display("FAIL quad_latency got %0d want 20", res_q[0].c - c0); else pass_cnt++;
      total_cnt++; if (res_q[0].v !== 4'b0100) $display("FAIL quad_res_valid got %b want 0100", res_q[0].v); else pass_cnt++;
      total_cnt++; if (res_q[0].cos !== 18'h3C000) $display("FAIL quad_cos got %h want 3c000", res_q[0].cos); else pass_cnt++;
      total_cnt++; if (res_q[0].sin !== 18'h00000) $display("FAIL quad_sin got %h want 00000", res_q[0].sin); else pass_cnt++;
    end
  endtask

  task automatic test_fairness();
    logic [N-1:0] exp_g;
    logic [DW-1:0] exp_a;
    do_reset();
    res_q.delete();
    @(negedge clk);
    req_valid = 4'b1111;
    for (int k = 0; k < N; k++) set_alpha(k, 18'h01000 * DW'(k + 1));
    for (int i = 0; i < 16; i++) begin
      #1;
      exp_g = 4'b0001 << (i % 4);
      total_cnt++; if (req_ready !== exp_g) $display("FAIL fair_grant_%0d got %b want %b", i, req_ready, exp_g); else pass_cnt++;
      @(negedge clk);
    end
    req_valid = '0;
    wait_results(16, 40);
    total_cnt++;
    if (res_q.size() != 16) $display("FAIL fair_result_count got %0d want 16", res_q.size());
    else begin
      pass_cnt++;
      for (int i = 0; i < 16; i++) begin
        exp_g = 4'b0001 << (i % 4);
        exp_a = 18'h01000 * DW'(i % 4 + 1);
        total_cnt++; if (res_q[i].v !== exp_g) $display("FAIL fair_res_order_%0d got %b want %b", i, res_q[i].v, exp_g); else pass_cnt++;
        total_cnt++; if (res_q[i].cos !== exp_a || res_q[i].sin !== ~exp_a) $display("FAIL fair_res_data_%0d got %h/%h want %h/%h", i, res_q[i].cos, res_q[i].sin, exp_a, ~exp_a); else pass_cnt++;
        total_cnt++; if (res_q[i].c !== res_q[0].c + i) $display("FAIL fair_res_spacing_%0d got %0d want %0d", i, res_q[i].c - res_q[0].c, i); else pass_cnt++;
      end
    end
  endtask

  task automatic test_range();
    res_q.delete();
    @(negedge clk);
    req_valid = 4'b0010; set_alpha(1, 18'h3FFFF);
    #1;
    total_cnt++; if (req_ready !== 4'b0010) $display("FAIL range_ready_neg got %b want 0010", req_ready); else pass_cnt++;
    @(negedge clk);
    set_alpha(1, 18'h19220);
    #1;
    total_cnt++; if (req_err !== 4'b0010) $display("FAIL range_err_neg got %b want 0010", req_err); else pass_cnt++;
    total_cnt++; if (eng_valid_o !== 1'b0) $display("FAIL range_no_issue_neg got %b want 0", eng_valid_o); else pass_cnt++;
    total_cnt++; if (req_ready !== 4'b0010) $display("FAIL range_ready_2pi got %b want 0010", req_ready); else pass_cnt++;
    @(negedge clk);
    req_valid = 4'b0110; set_alpha(2, 18'h00100);
    #1;
    total_cnt++; if (req_err !== 4'b0010) $display("FAIL range_err_2pi got %b want 0010", req_err); else pass_cnt++;
    total_cnt++; if (eng_valid_o !== 1'b0) $display("FAIL range_no_issue_2pi got %b want 0", eng_valid_o); else pass_cnt++;
    total_cnt++; if (req_ready !== 4'b0100) $display("FAIL range_next_grant got %b want 0100", req_ready); else pass_cnt++;
    @(negedge clk);
    req_valid = 4'b1000; set_alpha(3, 18'h1921F);
    #1;
    total_cnt++; if (req_err !== 4'b0000) $display("FAIL range_err_clear got %b want 0000", req_err); else pass_cnt++;
    total_cnt++; if (eng_valid_o !== 1'b1 || eng_alpha !== 18'h00100) $display("FAIL range_issue_r2 got %b/%h want 1/00100", eng_valid_o, eng_alpha); else pass_cnt++;
    @(negedge clk);
    req_valid = '0;
    #1;
    total_cnt++; if (eng_valid_o !== 1'b1 || eng_alpha !== 18'h1921F) $display("FAIL range_max_legal got %b/%h want 1/1921f", eng_valid_o, eng_alpha); else pass_cnt++;
    wait_results(3, 40);
    total_cnt++;
    if (res_q.size() != 2) $display("FAIL range_result_count got %0d want 2", res_q.size());
    else begin
      pass_cnt++;
      total_cnt++; if (res_q[0].v !== 4'b0100) $display("FAIL range_res0 got %b want 0100", res_q[0].v); else pass_cnt++;
      total_cnt++; if (res_q[1].v !== 4'b1000 || res_q[1].cos !== 18'h1921F) $display("FAIL range_res1 got %b/%h want 1000/1921f", res_q[1].v, res_q[1].cos); else pass_cnt++;
    end
  endtask

  task automatic test_enable();
    res_q.delete();
    @(negedge clk);
    req_valid = 4'b0001; set_alpha(0, 18'h00200);
    repeat (5) @(negedge clk);
    enable = 1'b0;
    #1;
    total_cnt++; if (req_ready !== 4'b0000) $display("FAIL enable_ready got %b want 0000", req_ready); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL enable_busy_inflight got %b want 1", busy); else pass_cnt++;
    repeat (25) @(negedge clk);
    #2;
    total_cnt++; if (res_q.size() != 5) $display("FAIL enable_result_count got %0d want 5", res_q.size()); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL enable_busy_drained got %b want 0", busy); else pass_cnt++;
    req_valid = '0;
    enable = 1'b1;
  endtask

  task automatic test_reset_midop();
    res_q.delete();
    @(negedge clk);
    req_valid = 4'b0001; set_alpha(0, 18'h00300);
    repeat (3) @(negedge clk);
    req_valid = '0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL midreset_busy got %b want 0", busy); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    #2;
    total_cnt++; if (res_q.size() != 0) $display("FAIL midreset_results got %0d want 0", res_q.size()); else pass_cnt++;
    total_cnt++; if (sync_err !== 1'b0) $display("FAIL midreset_sync_err got %b want 0", sync_err); else pass_cnt++;
  endtask

  task automatic test_sync_check();
    logic exp_err;
`ifdef CORDIC_ARB_SYNC_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    res_q.delete();
    drop = 1'b1;
    @(negedge clk);
    req_valid = 4'b0001; set_alpha(0, 18'h00000);
    @(negedge clk);
    req_valid = '0;
    repeat (25) @(negedge clk);
    #2;
    total_cnt++; if (res_q.size() != 1) $display("FAIL sync_still_routed got %0d want 1", res_q.size()); else pass_cnt++;
    total_cnt++; if (sync_err !== exp_err) $display("FAIL sync_err_set got %b want %b", sync_err, exp_err); else pass_cnt++;
    drop = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    total_cnt++; if (sync_err !== exp_err) $display("FAIL sync_err_sticky got %b want %b", sync_err, exp_err); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (sync_err !== 1'b0) $display("FAIL sync_err_reset got %b want 0", sync_err); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_quadrant();
    test_fairness();
    test_range();
    test_enable();
    test_reset_midop();
    test_sync_check();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
